// File: rtl/memory_parser.sv
`default_nettype none
// ============================================================================
// Module   : memory_parser
// Purpose  : Boot-image generator for the unified RISC-V memory. It streams a
//            fixed program word by word after reset and offers a combinational
//            read port plus a whole-image task.
// Revision : 1.0 - initial release
// ============================================================================
module memory_parser #(
  parameter int size   = 256,
  parameter int ADDR_W = $clog2(size)
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic [ADDR_W-1:0] init_addr,
  output logic [31:0]       init_data,
  output logic              init_we,
  output logic              init_done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SWEEP = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(size - 1);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic              r_done;

  // Single image table: the sweep, the read port and memory_contents all use it.
  function automatic logic [31:0] image_word(input int idx);
    logic [31:0] w;
    w = 32'h0;
    if (idx >= 0 && idx < size) begin
      case (idx)
        0:       w = 32'h0050_0093;
        1:       w = 32'h00A0_0113;
        2:       w = 32'h0020_81B3;
        3:       w = 32'h0030_2023;
        4:       w = 32'h0000_006F;
        default: w = 32'h0;
      endcase
    end
    return w;
  endfunction

  task automatic memory_contents(output logic [31:0] m [0:size-1]);
    for (int i = 0; i < size; i++) begin
      m[i] = image_word(i);
    end
  endtask

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= c_IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_state <= c_SWEEP;
          r_addr  <= '0;
          r_we    <= 1'b1;
        end
        c_SWEEP: begin
          if (r_addr == c_LAST) begin
            r_state <= c_DONE;
            r_we    <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        c_DONE: begin
          r_state <= c_DONE;
        end
        default: begin
          r_state <= c_IDLE;
          r_addr  <= '0;
          r_we    <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign init_addr = r_addr;
  assign init_we   = r_we;
  assign init_done = r_done;
  assign init_data = image_word(int'(r_addr));
  assign rd_data   = image_word(int'(rd_addr));

endmodule
`default_nettype wire

// File: tb/tb_memory_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_parser
// Purpose  : Self-checking bench for memory_parser at depths 256 and 10.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_parser;

  localparam int c_SZ_A = 256;
  localparam int c_SZ_B = 10;

  logic       Clk;
  logic       Reset;
  logic [7:0] rd_addr_a;
  logic [3:0] rd_addr_b;

  logic [7:0]  w_init_addr_a;
  logic [31:0] w_init_data_a;
  logic        w_init_we_a;
  logic        w_init_done_a;
  logic [31:0] w_rd_data_a;

  logic [3:0]  w_init_addr_b;
  logic [31:0] w_init_data_b;
  logic        w_init_we_b;
  logic        w_init_done_b;
  logic [31:0] w_rd_data_b;

  int n_tests = 0;
  int n_fail  = 0;
  int r_cnt   = 0;   // non-reset edges since the last reset edge

  logic [31:0] c_prog [0:4] = '{32'h00500093, 32'h00A00113, 32'h002081B3,
                                32'h00302023, 32'h0000006F};
  logic [31:0] arr [0:c_SZ_A-1];

  memory_parser #(.size(c_SZ_A)) dut (
    .Clk(Clk), .Reset(Reset),
    .init_addr(w_init_addr_a), .init_data(w_init_data_a),
    .init_we(w_init_we_a), .init_done(w_init_done_a),
    .rd_addr(rd_addr_a), .rd_data(w_rd_data_a)
  );

  memory_parser #(.size(c_SZ_B)) dut10 (
    .Clk(Clk), .Reset(Reset),
    .init_addr(w_init_addr_b), .init_data(w_init_data_b),
    .init_we(w_init_we_b), .init_done(w_init_done_b),
    .rd_addr(rd_addr_b), .rd_data(w_rd_data_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t cnt=%0d)", tag, got, exp, $time, r_cnt);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a, input int sz);
    if (a >= sz) return 32'h0;
    if (a < 5) return c_prog[a];
    return 32'h0;
  endfunction

  // Expected sweep outputs for a depth, from the edge count since reset.
  task automatic check_sweep(input string nm, input int sz, input logic [31:0] addr,
                             input logic [31:0] data, input logic we, input logic done);
    int ea;
    logic ewe, edone;
    if (r_cnt == 0) begin
      ea = 0; ewe = 1'b0; edone = 1'b0;
    end else if (r_cnt <= sz) begin
      ea = r_cnt - 1; ewe = 1'b1; edone = 1'b0;
    end else begin
      ea = sz - 1; ewe = 1'b0; edone = 1'b1;
    end
    check({nm, ".addr"}, addr, 32'(ea));
    check({nm, ".we"},   {31'b0, we},   {31'b0, ewe});
    check({nm, ".done"}, {31'b0, done}, {31'b0, edone});
    check({nm, ".data"}, data, ref_word(ea, sz));
  endtask

  task automatic step();
    @(posedge Clk);
    if (Reset) r_cnt = 0;
    else       r_cnt++;
    #1;
    check_sweep("A", c_SZ_A, 32'(w_init_addr_a), w_init_data_a, w_init_we_a, w_init_done_a);
    check_sweep("B", c_SZ_B, 32'(w_init_addr_b), w_init_data_b, w_init_we_b, w_init_done_b);
    check("A.rd", w_rd_data_a, ref_word(int'(rd_addr_a), c_SZ_A));
    check("B.rd", w_rd_data_b, ref_word(int'(rd_addr_b), c_SZ_B));
    rd_addr_a = 8'($urandom_range(0, 255));
    rd_addr_b = 4'($urandom_range(0, 15));
  endtask

  task automatic rd_probe(input logic [7:0] a, input logic [3:0] b);
    rd_addr_a = a;
    rd_addr_b = b;
    #1;
    check("A.rdp", w_rd_data_a, ref_word(int'(a), c_SZ_A));
    check("B.rdp", w_rd_data_b, ref_word(int'(b), c_SZ_B));
  endtask

  task automatic run_to_done();
    while (r_cnt < c_SZ_A + 3) step();
  endtask

  initial begin
    int abort_at;
    Reset     = 1'b1;
    rd_addr_a = 8'd0;
    rd_addr_b = 4'd0;

    // Whole-image task at time zero
    dut.memory_contents(arr);
    for (int i = 0; i < c_SZ_A; i++) begin
      check($sformatf("mem[%0d]", i), arr[i], ref_word(i, c_SZ_A));
    end

    // Reset for two cycles, then a full sweep
    step();
    step();
    Reset = 1'b0;
    run_to_done();

    rd_probe(8'd2, 4'd12);
    rd_probe(8'd4, 4'd4);
    rd_probe(8'd200, 4'd9);
    rd_probe(8'd0, 4'd15);

    // Abort at address 100
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    while (r_cnt < 101) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    run_to_done();

    // Randomised abort points and reset lengths
    for (int k = 0; k < 3; k++) begin
      abort_at = $urandom_range(1, c_SZ_A + 2);
      while (r_cnt < abort_at) step();
      Reset = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      Reset = 1'b0;
    end
    run_to_done();

    // Reset while done reruns the sweep
    repeat (4) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    run_to_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
